// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard controller: stall-cause encodings and
// the per-stage scoreboard entry.
package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_RUN   = 2'd0,
    CAUSE_LU    = 2'd1,
    CAUSE_MEM   = 2'd2,
    CAUSE_FLUSH = 2'd3
  } stall_cause_e;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request and hazard-response bundle; master drives the ID
// instruction, slave (the controller) returns stall/forward decisions.
interface hazard_ctrl_if #(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int SELW      = $clog2(FWD_DEPTH + 1)
);
  logic                      id_valid;
  logic [NUM_SRC*5-1:0]      id_rs;
  logic [NUM_SRC-1:0]        id_re;
  logic [4:0]                id_rd;
  logic                      id_we;
  logic                      id_is_load;
  logic                      flush;
  logic                      mem_busy;
  logic                      stall_if;
  logic                      stall_id;
  logic                      bubble_ex;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic [1:0]                stall_cause;
  logic [15:0]               stall_cnt;

  modport master (
    output id_valid, id_rs, id_re, id_rd, id_we, id_is_load, flush, mem_busy,
    input  stall_if, stall_id, bubble_ex, fwd_sel, stall_cause, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_re, id_rd, id_we, id_is_load, flush, mem_busy,
    output stall_if, stall_id, bubble_ex, fwd_sel, stall_cause, stall_cnt
  );
endinterface

// File: rtl/fwd_prio_enc.sv
// Per-source-port priority match against the scoreboard: picks the youngest
// writing stage and flags a load result that is not yet forwardable.
module fwd_prio_enc
  import hazard_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int SELW      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        re_i,
  input  logic [4:0]                  rs_i,
  input  sb_entry_t [FWD_DEPTH-1:0]   sb_i,
  output logic [SELW-1:0]             sel_o,
  output logic                        lu_o
);

  // Scan from the youngest stage; the first hit wins.
  always_comb begin
    logic found;
    logic hit;
    sel_o = '0;
    lu_o  = 1'b0;
    found = 1'b0;
    hit   = 1'b0;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      hit = re_i && (rs_i != 5'd0) && sb_i[k-1].valid && sb_i[k-1].we &&
            (sb_i[k-1].rd == rs_i) && !found;
      if (hit) begin
        sel_o = SELW'(k);
        lu_o  = sb_i[k-1].is_load && (k <= LOAD_LAT);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks downstream writers, selects forwarding
// paths, and arbitrates mem_busy / flush / load-use stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int SELW = $clog2(FWD_DEPTH + 1);

  sb_entry_t [FWD_DEPTH-1:0] sb_q, sb_d;
  stall_cause_e              cause_q, cause_d;
  logic [15:0]               cnt_q, cnt_d;

  logic [NUM_SRC-1:0]      port_lu_s;
  logic [NUM_SRC*SELW-1:0] fwd_sel_s;
  logic                    mem_s, flush_s, lu_s, stall_id_s;
  sb_entry_t               stage1_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
    fwd_prio_enc #(
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SELW      (SELW)
    ) u_enc (
      .re_i  (bus.id_re[i]),
      .rs_i  (bus.id_rs[5*i +: 5]),
      .sb_i  (sb_q),
      .sel_o (fwd_sel_s[SELW*i +: SELW]),
      .lu_o  (port_lu_s[i])
    );
  end

  // Gating with reset keeps every stall output low while reset is held,
  // even if mem_busy or flush are asserted by upstream logic.
  always_comb begin
    mem_s      = reset && bus.mem_busy;
    flush_s    = reset && !bus.mem_busy && bus.flush;
    lu_s       = reset && !bus.mem_busy && !bus.flush && bus.id_valid && (|port_lu_s);
    stall_id_s = mem_s || lu_s;
  end

  assign bus.stall_if    = stall_id_s;
  assign bus.stall_id    = stall_id_s;
  assign bus.bubble_ex   = flush_s || lu_s;
  assign bus.fwd_sel     = fwd_sel_s;
  assign bus.stall_cause = cause_q;
  assign bus.stall_cnt   = cnt_q;

  // Next-state: freeze on mem_busy, otherwise shift with a bubble or the ID op.
  always_comb begin
    sb_d     = sb_q;
    cause_d  = CAUSE_RUN;
    stage1_s = '0;
    if (flush_s || lu_s) begin
      stage1_s = '0;
    end else begin
      stage1_s = '{valid: bus.id_valid, we: bus.id_we, rd: bus.id_rd, is_load: bus.id_is_load};
    end
    if (mem_s) begin
      cause_d = CAUSE_MEM;
    end else begin
      sb_d[0] = stage1_s;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      if (flush_s) begin
        cause_d = CAUSE_FLUSH;
      end else if (lu_s) begin
        cause_d = CAUSE_LU;
      end else begin
        cause_d = CAUSE_RUN;
      end
    end
    if (stall_id_s && (cnt_q != STALL_CNT_MAX)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_q    <= '0;
      cause_q <= CAUSE_RUN;
      cnt_q   <= 16'd0;
    end else begin
      sb_q    <= sb_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
